// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard: per-GPR in-flight write counters, decode stall and busy mask.
// Optional macro SB_WB_BYPASS_EN lets a reader issue in the cycle its source's last write retires.
module reg_scoreboard #(
    parameter int NREG   = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ds_valid,
    input  logic [ADDR_W-1:0] ds_src1,
    input  logic              ds_src1_en,
    input  logic [ADDR_W-1:0] ds_src2,
    input  logic              ds_src2_en,
    input  logic [ADDR_W-1:0] ds_dest,
    input  logic              ds_dest_en,
    input  logic              es_allowin,
    output logic              ds_stall,
    output logic              ds_issue,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_dest,
    input  logic              wb_dest_en,
    input  logic              flush,
    output logic [NREG-1:0]   busy_mask,
    output logic              sb_err
);

    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

    logic [CNT_W-1:0] cnt_r     [NREG];
    logic [CNT_W-1:0] cnt_nxt_s [NREG];
    logic [NREG-1:0]  busy_nxt_s;
    logic [NREG-1:0]  busy_mask_r;
    logic             sb_err_r;
    logic             src1_haz_s;
    logic             src2_haz_s;
    logic             dest_sat_s;
    logic             inc_s;
    logic             dec_s;
    logic             underflow_s;

    assign dec_s = wb_valid & wb_dest_en & (wb_dest != ADDR_ZERO);
    assign inc_s = ds_issue & ds_dest_en & (ds_dest != ADDR_ZERO);

    // Hazard detection; loops start at 1 so r0 and out-of-range indices never match.
    always_comb begin
        logic last_v;
        src1_haz_s = 1'b0;
        src2_haz_s = 1'b0;
        dest_sat_s = 1'b0;
        last_v     = 1'b0;
        for (int i = 1; i < NREG; i++) begin
`ifdef SB_WB_BYPASS_EN
            last_v = dec_s & (wb_dest == ADDR_W'(i)) & (cnt_r[i] == CNT_ONE);
`else
            last_v = 1'b0;
`endif
            src1_haz_s = src1_haz_s | (ds_src1_en & (ds_src1 == ADDR_W'(i)) &
                                       (cnt_r[i] != CNT_ZERO) & ~last_v);
            src2_haz_s = src2_haz_s | (ds_src2_en & (ds_src2 == ADDR_W'(i)) &
                                       (cnt_r[i] != CNT_ZERO) & ~last_v);
            dest_sat_s = dest_sat_s | (ds_dest_en & (ds_dest == ADDR_W'(i)) &
                                       (cnt_r[i] == CNT_MAX));
        end
    end

    assign ds_stall = ds_valid & (src1_haz_s | src2_haz_s | dest_sat_s);
    assign ds_issue = ds_valid & es_allowin & ~ds_stall;

    // Next-state counters: flush wins, a matched inc/dec pair cancels, underflow saturates at 0.
    always_comb begin
        logic inc_v;
        logic dec_v;
        underflow_s  = 1'b0;
        inc_v        = 1'b0;
        dec_v        = 1'b0;
        cnt_nxt_s[0] = CNT_ZERO;
        for (int i = 1; i < NREG; i++) begin
            inc_v = inc_s & (ds_dest == ADDR_W'(i));
            dec_v = dec_s & (wb_dest == ADDR_W'(i));
            cnt_nxt_s[i] = cnt_r[i];
            if (flush) begin
                cnt_nxt_s[i] = CNT_ZERO;
            end else if (inc_v && !dec_v) begin
                cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
            end else if (dec_v && !inc_v) begin
                if (cnt_r[i] == CNT_ZERO) begin
                    underflow_s = 1'b1;
                end else begin
                    cnt_nxt_s[i] = cnt_r[i] - CNT_ONE;
                end
            end else begin
                cnt_nxt_s[i] = cnt_r[i];
            end
        end
    end

    // Busy bits come from next-state counters so the mask tracks the counter registers exactly.
    always_comb begin
        busy_nxt_s = {NREG{1'b0}};
        for (int i = 0; i < NREG; i++) begin
            busy_nxt_s[i] = (cnt_nxt_s[i] != CNT_ZERO);
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
            busy_mask_r <= {NREG{1'b0}};
            sb_err_r    <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
            busy_mask_r <= busy_nxt_s;
            sb_err_r    <= sb_err_r | underflow_s;
        end
    end

    assign busy_mask = busy_mask_r;
    assign sb_err    = sb_err_r;

endmodule
